// File: rtl/pn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pn_pkg
//  Purpose  : Shared types, constants and LFSR step function for the
//             PN burst arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package pn_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int           LFSR_W   = 3;
   // Reset / lock-up replacement state {s1,s2,s3}
   localparam logic [2:0]   LFSR_RST = 3'b100;

   // One LFSR step on {s1,s2,s3}: s1<=s1^s3, s2<=s1, s3<=s2 (period 7)
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[2] ^ s[0], s[2], s[1]};
   endfunction

endpackage : pn_pkg
`default_nettype wire

// File: rtl/pn_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pn_burst_arbiter_if
//  Purpose  : Request / grant / random-beat bundle between traffic clients
//             and the PN burst arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface pn_burst_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int CNT_W = 4
);
   logic [NREQ-1:0]       i_req;
   logic [NREQ*CNT_W-1:0] i_len;
   logic                  i_seed_we;
   logic [2:0]            i_seed;
   logic [NREQ-1:0]       o_gnt;
   logic                  o_rand_vld;
   logic [1:0]            o_rand;
   logic                  o_done;
   logic                  o_busy;

   // Client side drives requests and observes beats
   modport master (
      output i_req, i_len, i_seed_we, i_seed,
      input  o_gnt, o_rand_vld, o_rand, o_done, o_busy
   );

   // Arbiter side
   modport slave (
      input  i_req, i_len, i_seed_we, i_seed,
      output o_gnt, o_rand_vld, o_rand, o_done, o_busy
   );
endinterface : pn_burst_arbiter_if
`default_nettype wire

// File: rtl/pn_step_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : pn_step_lfsr
//  Purpose  : 3-bit seedable LFSR that steps only when enabled; exposes the
//             2-bit random value {s3,s2} of the current state.
//  Revision : 1.0  initial release
// ============================================================================
module pn_step_lfsr
   import pn_pkg::*;
(
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_en,
   input  wire logic              i_ld,
   input  wire logic [LFSR_W-1:0] i_ld_val,
   output logic      [1:0]        o_rand
);

   logic [LFSR_W-1:0] r_state;
   logic [LFSR_W-1:0] w_ld_val;

   // All-zero is the lock-up state, so a zero seed restarts from LFSR_RST
   assign w_ld_val = (i_ld_val == '0) ? LFSR_RST : i_ld_val;

   // State register: load beats step, step only on delivered beats
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LFSR_RST;
      end else if (i_ld) begin
         r_state <= w_ld_val;
      end else if (i_en) begin
         r_state <= lfsr_next(r_state);
      end
   end

   assign o_rand = {r_state[0], r_state[1]};

endmodule : pn_step_lfsr
`default_nettype wire

// File: rtl/pn_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pn_burst_arbiter
//  Purpose  : Round-robin arbiter sharing one PN source among NREQ
//             requesters; each grant delivers a burst of len+1 random beats.
//  Revision : 1.0  initial release
// ============================================================================
module pn_burst_arbiter
   import pn_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int CNT_W = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pn_burst_arbiter_if.slave  bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t            r_state;
   state_t            w_state_next;
   logic [NREQ-1:0]   r_gnt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  r_gidx;
   logic [CNT_W-1:0]  r_cnt;

   logic [CNT_W-1:0]  w_len_arr [NREQ];
   logic [PTR_W-1:0]  w_pick;
   logic [NREQ-1:0]   w_pick_oh;
   logic              w_found;
   logic              w_grant;
   logic              w_beat;
   logic              w_last;
   logic              w_seed_ld;
   logic [1:0]        w_rand;

   // Index a+b wrapped into 0..NREQ-1 (b < NREQ)
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
      int v_sum;
      v_sum = int'(a) + b;
      if (v_sum >= NREQ) begin
         v_sum = v_sum - NREQ;
      end
      return PTR_W'(v_sum);
   endfunction

   // Split the flat length bus into per-requester fields
   generate
      for (genvar g = 0; g < NREQ; g++) begin : g_len
         assign w_len_arr[g] = bus.i_len[g*CNT_W +: CNT_W];
      end
   endgenerate

   // Round-robin pick: first requester at or after the pointer, wrapping
   always_comb begin
      w_found   = 1'b0;
      w_pick    = '0;
      w_pick_oh = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && bus.i_req[wrap_add(r_ptr, k)]) begin
            w_found = 1'b1;
            w_pick  = wrap_add(r_ptr, k);
         end
      end
      w_pick_oh[w_pick] = 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and per-cycle strobes
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_beat       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant      = 1'b1;
               w_state_next = BURST;
            end
         end
         BURST: begin
            w_beat = 1'b1;
            if (r_cnt == '0) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Grant, beat counter and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt  <= '0;
         r_ptr  <= '0;
         r_gidx <= '0;
         r_cnt  <= '0;
      end else if (w_grant) begin
         r_gnt  <= w_pick_oh;
         r_gidx <= w_pick;
         r_cnt  <= w_len_arr[w_pick];
      end else if (w_beat) begin
         if (w_last) begin
            r_gnt <= '0;
            r_ptr <= wrap_add(r_gidx, 1);
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Seeds are only honoured between bursts so a burst sees one sequence
   assign w_seed_ld = (r_state == IDLE) && bus.i_seed_we;

   pn_step_lfsr u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_beat),
      .i_ld     (w_seed_ld),
      .i_ld_val (bus.i_seed),
      .o_rand   (w_rand)
   );

   assign bus.o_gnt      = r_gnt;
   assign bus.o_rand_vld = w_beat;
   assign bus.o_busy     = w_beat;
   assign bus.o_done     = w_last;
   assign bus.o_rand     = w_rand;

endmodule : pn_burst_arbiter
`default_nettype wire

// File: tb/tb_pn_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pn_burst_arbiter
//  Purpose  : Scoreboard bench for pn_burst_arbiter (NREQ=2, CNT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pn_burst_arbiter;

   localparam int NREQ  = 2;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic [1:0]      rnd;
      logic            done;
   } exp_t;

   logic clk;
   logic rst;
   logic mon_en;
   logic prev_done;
   int   checks;
   int   errors;
   exp_t q[$];

   pn_burst_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   pn_burst_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [NREQ-1:0] g, input logic [1:0] r, input logic d);
      exp_t e;
      e.gnt  = g;
      e.rnd  = r;
      e.done = d;
      q.push_back(e);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sync();
      rst = 1'b0;
   endtask

   // Returns on the first rising edge after all expected beats were seen
   task automatic wait_empty(input int max_cyc);
      int n;
      n = 0;
      while (q.size() != 0 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      chk("burst_complete_in_time", 32'(q.size()), 32'd0);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},  32'(bus.o_gnt),      32'd0);
      chk({tag, "_vld"},  32'(bus.o_rand_vld), 32'd0);
      chk({tag, "_done"}, 32'(bus.o_done),     32'd0);
      chk({tag, "_busy"}, 32'(bus.o_busy),     32'd0);
      chk({tag, "_rand"}, 32'(bus.o_rand),     32'd0);
   endtask

   // Monitor: every beat pops one expected entry; idle cycles must be quiet
   initial begin
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (prev_done) begin
               chk("gap_after_done", 32'(bus.o_rand_vld), 32'd0);
            end
            if (bus.o_rand_vld === 1'b1) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got gnt=%0h rand=%0h expected no beat at %0t",
                           bus.o_gnt, bus.o_rand, $time);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("beat_gnt",  32'(bus.o_gnt),  32'(e.gnt));
                  chk("beat_rand", 32'(bus.o_rand), 32'(e.rnd));
                  chk("beat_done", 32'(bus.o_done), 32'(e.done));
                  chk("beat_busy", 32'(bus.o_busy), 32'd1);
               end
            end else begin
               chk("idle_gnt",  32'(bus.o_gnt),  32'd0);
               chk("idle_done", 32'(bus.o_done), 32'd0);
               chk("idle_busy", 32'(bus.o_busy), 32'd0);
            end
            prev_done = (bus.o_done === 1'b1);
         end
      end
   end

   // Stimulus
   initial begin
      checks        = 0;
      errors        = 0;
      mon_en        = 1'b0;
      rst           = 1'b1;
      bus.i_req     = '0;
      bus.i_len     = '0;
      bus.i_seed_we = 1'b0;
      bus.i_seed    = 3'b000;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      sync();
      rst    = 1'b0;
      mon_en = 1'b1;

      // T1: req0, len 6 -> 7 beats walking the full LFSR period
      push(2'b01, 2'b00, 1'b0);
      push(2'b01, 2'b01, 1'b0);
      push(2'b01, 2'b11, 1'b0);
      push(2'b01, 2'b11, 1'b0);
      push(2'b01, 2'b10, 1'b0);
      push(2'b01, 2'b01, 1'b0);
      push(2'b01, 2'b10, 1'b1);
      bus.i_len = {4'd0, 4'd6};
      bus.i_req = 2'b01;
      sync();
      bus.i_req = 2'b00;
      @(negedge clk);
      chk("t1_first_beat_latency", 32'(bus.o_rand_vld), 32'd1);
      wait_empty(50);
      @(negedge clk);
      chk("t1_lfsr_back_to_100", 32'(bus.o_rand), 32'd0);
      repeat (2) sync();

      // T2: both requesting -> req0, gap, req1, gap, req0
      do_reset();
      push(2'b01, 2'b00, 1'b1);
      push(2'b10, 2'b01, 1'b0);
      push(2'b10, 2'b11, 1'b1);
      push(2'b01, 2'b11, 1'b1);
      bus.i_len = {4'd1, 4'd0};
      bus.i_req = 2'b11;
      wait_empty(50);
      bus.i_req = 2'b00;
      repeat (3) sync();

      // T3: zero seed remaps to 100; seed and grant on the same edge
      bus.i_seed    = 3'b000;
      bus.i_seed_we = 1'b1;
      sync();
      bus.i_seed_we = 1'b0;
      @(negedge clk);
      chk("t3_zero_seed_remap", 32'(bus.o_rand), 32'd0);
      sync();
      push(2'b01, 2'b00, 1'b1);
      bus.i_len = {4'd0, 4'd0};
      bus.i_req = 2'b01;
      sync();
      bus.i_req = 2'b00;
      wait_empty(20);
      sync();
      bus.i_seed    = 3'b101;
      bus.i_seed_we = 1'b1;
      push(2'b01, 2'b10, 1'b1);
      bus.i_req     = 2'b01;
      sync();
      bus.i_seed_we = 1'b0;
      bus.i_req     = 2'b00;
      wait_empty(20);
      repeat (2) sync();

      // T4: seed and req drop mid-burst are ignored
      do_reset();
      push(2'b01, 2'b00, 1'b0);
      push(2'b01, 2'b01, 1'b0);
      push(2'b01, 2'b11, 1'b0);
      push(2'b01, 2'b11, 1'b1);
      bus.i_len = {4'd0, 4'd3};
      bus.i_req = 2'b01;
      sync();
      sync();
      bus.i_req     = 2'b00;
      bus.i_seed    = 3'b010;
      bus.i_seed_we = 1'b1;
      sync();
      sync();
      bus.i_seed_we = 1'b0;
      wait_empty(20);
      @(negedge clk);
      chk("t4_seed_ignored_state_101", 32'(bus.o_rand), 32'd2);
      repeat (2) sync();

      // T5: reset on the 3rd beat of a 5-beat burst (LFSR at 101, ptr 1)
      push(2'b10, 2'b10, 1'b0);
      push(2'b10, 2'b01, 1'b0);
      push(2'b10, 2'b10, 1'b0);
      bus.i_len = {4'd4, 4'd0};
      bus.i_req = 2'b10;
      sync();
      bus.i_req = 2'b00;
      sync();
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("t5_midburst_reset");
      chk("t5_beats_before_reset", 32'(q.size()), 32'd0);
      sync();
      push(2'b01, 2'b00, 1'b1);
      push(2'b10, 2'b01, 1'b0);
      push(2'b10, 2'b11, 1'b1);
      bus.i_len = {4'd1, 4'd0};
      bus.i_req = 2'b11;
      wait_empty(50);
      bus.i_req = 2'b00;
      repeat (2) sync();

      // T6: idle for 10 cycles, LFSR holds at 011
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t6_idle_rand_hold", 32'(bus.o_rand), 32'd3);
      end

      chk("final_queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_pn_burst_arbiter
`default_nettype wire

// File: doc/pn_burst_arbiter.md
Name: pn_burst_arbiter

Overview:
- Shares one 3-bit pseudo-random pattern source between NREQ requesters.
- Each granted requester receives a burst of 2-bit random values, one per cycle.
- Arbitration is round-robin; the source is seedable and advances only on delivered beats.
- Sits between the stimulus/traffic clients and the PN generation logic, which is instantiated inside this block.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CNT_W, 4, width of each per-requester burst-length field.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester burst request (level).
- len  input  NREQ*CNT_W  per-requester length field; field i = len[i*CNT_W +: CNT_W]; burst = field+1 beats.
- seed_we  input  1  load LFSR state from seed.
- seed  input  3  new state {s1,s2,s3}.
- gnt  output  NREQ  one-hot grant, held for the whole burst.
- rand_vld  output  1  rand valid this cycle (beat).
- rand  output  2  random value {s3,s2}.
- done  output  1  single-cycle pulse on the last beat of a burst.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (rst=1 at clk edge), regardless of state, including mid-burst:
  - state=IDLE, gnt=0, rand_vld=0, done=0, busy=0.
  - LFSR={s1,s2,s3}=100, so rand=00.
  - RR pointer=0, beat counter=0.
- LFSR step: s1<=s1^s3; s2<=s1; s3<=s2. Period 7.
- LFSR sequence from 100: 100,110,111,011,101,010,001,100. Matching rand: 00,01,11,11,10,01,10,00.
- LFSR advances only on cycles with rand_vld=1; otherwise it holds.
- rand is always {s3,s2} of the current state, combinational from state registers; it is also visible when rand_vld=0.
- FSM, two states:
  - IDLE: if any req bit is set at a clk edge:
    - pick the first requester at or after the RR pointer (wrapping);
    - register the one-hot gnt;
    - load the counter with that requester's len field;
    - go to BURST.
  - BURST: rand_vld=1, busy=1, gnt held.
    - If counter != 0, decrement it.
    - If counter == 0, this is the last beat: done=1. Next edge: gnt=0, RR pointer = granted index+1 mod NREQ, go to IDLE.
- Latency and gap:
  - req high in IDLE at edge t gives gnt/rand_vld from cycle t+1.
  - A burst with len=L lasts exactly L+1 cycles.
  - At least one IDLE cycle separates consecutive bursts.
- req is sampled only in IDLE. Deasserting req mid-burst has no effect; the burst completes. len is sampled only at grant.
- Seed load:
  - seed_we in IDLE loads seed into the LFSR at the next edge.
  - seed=000 (lock-up state) is replaced by 100.
  - seed_we during BURST is ignored.
  - If seed_we and a grant occur on the same IDLE edge, the seed loads first. The burst's first beat is then the seeded value.
- gnt is always one-hot or zero. rand_vld==busy. done is only ever high together with rand_vld.

Decomposition:
- Shared package pn_pkg holds:
  - state enum {IDLE, BURST};
  - LFSR_RST=3'b100, LFSR_W=3;
  - the lfsr_next function (s1^s3 feedback).
- One sub-module, pn_step_lfsr:
  - ports: clk, rst, en, ld, ld_val[2:0], rand[1:0];
  - synchronous active-high reset to 100;
  - ld has priority over en;
  - 000 is remapped to 100.
- The arbiter/FSM/counter stay in the top.

Test Plan:
- Reset, then req=01 with len0=6 → gnt=01 from the next cycle for 7 cycles. rand=00,01,11,11,10,01,10 with rand_vld=1. done on the 7th beat, then IDLE; LFSR back at 100.
- req=11 held, len0=0, len1=1 → grants go req0 (1 beat, rand=00), IDLE, req1 (2 beats, rand=01,11), IDLE, req0 (rand=11). Confirms round-robin and the one-cycle gap.
- seed_we=1 with seed=000 in IDLE, then req0 with len0=0 → single beat with rand=00 (state 100). Repeat with seed=101 → rand=10.
- Mid-burst seed_we=1 with seed=010, and req dropped on the 2nd beat (len=3) → burst still delivers 4 beats continuing the unseeded sequence; seed is ignored.
- rst asserted on the 3rd beat of a 5-beat burst → the next cycle has gnt=0, rand_vld=0, done=0, busy=0, rand=00. A new req restarts from state 100 with RR pointer 0.
- Idle with no req for 10 cycles → rand stays constant; LFSR does not advance.
